// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control unit: walks the shared datapath through fetch/decode/execute,
// stalls on memory wait states, traps on unsupported opcodes and counts retired instructions.
module multicycle_control_fsm #(
  parameter bit         MEM_WAIT_EN     = 1'b1,
  parameter bit         TRAP_ON_ILLEGAL = 1'b1,
  parameter int         CNT_W           = 32,
  parameter logic [5:0] ALU_ADD         = 6'b100000,
  parameter logic [5:0] ALU_SUB         = 6'b100010
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [5:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetireCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retire_s;
  logic             ready_s;
  logic             pcw_s, iord_s, mrd_s, mwr_s, irw_s, rdst_s, m2r_s, rw_s, srca_s, ill_s;
  logic [1:0]       srcb_s, pcsrc_s;
  logic [5:0]       aluop_s;

  assign ready_s = MEM_WAIT_EN ? MemReady : 1'b1;

  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (ready_s) state_d = S_DECODE;
        else         state_d = S_FETCH;
      end
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d = S_TRAP;
            end else begin
              state_d  = S_FETCH;
              retire_s = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        if (Opcode == OP_LW)      state_d = S_MEMRD;
        else if (Opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        if (ready_s) state_d = S_MEMWB;
        else         state_d = S_MEMRD;
      end
      // A store retires only in the cycle memory accepts it.
      S_MEMWR: begin
        if (ready_s) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEMWR;
        end
      end
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire_s) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else          cnt_q <= cnt_q;
    end
  end

  always_comb begin
    pcw_s   = 1'b0;  iord_s = 1'b0;  mrd_s  = 1'b0;  mwr_s  = 1'b0;
    irw_s   = 1'b0;  rdst_s = 1'b0;  m2r_s  = 1'b0;  rw_s   = 1'b0;
    srca_s  = 1'b0;  srcb_s = 2'd0;  pcsrc_s = 2'd0; aluop_s = ALU_ADD;
    ill_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mrd_s  = 1'b1;
        srcb_s = 2'd1;
        if (ready_s) begin
          irw_s = 1'b1;
          pcw_s = 1'b1;
        end else begin
          irw_s = 1'b0;
          pcw_s = 1'b0;
        end
      end
      S_DECODE: srcb_s = 2'd3;
      S_MEMADR, S_ADDIEX: begin
        srca_s = 1'b1;
        srcb_s = 2'd2;
      end
      S_MEMRD: begin
        mrd_s  = 1'b1;
        iord_s = 1'b1;
      end
      S_MEMWB: begin
        rw_s  = 1'b1;
        m2r_s = 1'b1;
      end
      S_MEMWR: begin
        mwr_s  = 1'b1;
        iord_s = 1'b1;
      end
      S_EXEC: begin
        srca_s  = 1'b1;
        aluop_s = Funct;
      end
      S_RWB: begin
        rw_s   = 1'b1;
        rdst_s = 1'b1;
      end
      S_BRANCH: begin
        srca_s  = 1'b1;
        aluop_s = ALU_SUB;
        pcsrc_s = 2'd1;
        pcw_s   = Zero;
      end
      S_JUMP: begin
        pcw_s   = 1'b1;
        pcsrc_s = 2'd2;
      end
      S_ADDIWB: rw_s  = 1'b1;
      S_TRAP:   ill_s = 1'b1;
      default: begin
        ill_s = 1'b0;
      end
    endcase
  end

  // Reset forces every control line low immediately so an aborted access cannot complete.
  assign PCWrite     = Rst & pcw_s;
  assign IorD        = Rst & iord_s;
  assign MemRead     = Rst & mrd_s;
  assign MemWrite    = Rst & mwr_s;
  assign IRWrite     = Rst & irw_s;
  assign RegDst      = Rst & rdst_s;
  assign MemtoReg    = Rst & m2r_s;
  assign RegWrite    = Rst & rw_s;
  assign ALUSrcA     = Rst & srca_s;
  assign ALUSrcB     = Rst ? srcb_s  : 2'b00;
  assign ALUOp       = Rst ? aluop_s : 6'b000000;
  assign PCSource    = Rst ? pcsrc_s : 2'b00;
  assign Illegal     = Rst & ill_s;
  assign State       = state_q;
  assign RetireCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: table rows scored cycle by cycle through a queue, plus
// hand sequences for reset abort, trap exit, no-wait memory, illegal-as-NOP and counter wrap.
module tb_multicycle_control_fsm;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_OR = 6'b100101;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_ILL = 6'b111111;

  typedef struct packed {
    logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
    logic [1:0] srcb;
    logic [5:0] aluop;
    logic [1:0] pcsrc;
    logic ill;
  } ctl_t;

  typedef struct {
    int          id;
    logic [5:0]  op, fn;
    logic        z, rdy;
    logic [3:0]  st;
    ctl_t        ctl;
    logic [31:0] cnt;
  } row_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Rst, Zero, MemReady;
  logic [5:0] Opcode, Funct;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [5:0] ALUOp;
  logic [3:0] State;
  logic       Illegal;
  logic [31:0] RetireCount;

  logic       Rst2, Zero2, MemReady2;
  logic [5:0] Opcode2, Funct2;
  logic       PCWrite2, IorD2, MemRead2, MemWrite2, IRWrite2, RegDst2, MemtoReg2, RegWrite2, ALUSrcA2;
  logic [1:0] ALUSrcB2, PCSource2;
  logic [5:0] ALUOp2;
  logic [3:0] State2;
  logic       Illegal2;
  logic [3:0] RetireCount2;

  multicycle_control_fsm dut (
    .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .State(State), .Illegal(Illegal),
    .RetireCount(RetireCount)
  );

  multicycle_control_fsm #(.MEM_WAIT_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)) dut2 (
    .Clk(Clk), .Rst(Rst2), .Opcode(Opcode2), .Funct(Funct2), .Zero(Zero2), .MemReady(MemReady2),
    .PCWrite(PCWrite2), .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .RegDst(RegDst2), .MemtoReg(MemtoReg2), .RegWrite(RegWrite2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .PCSource(PCSource2), .State(State2), .Illegal(Illegal2),
    .RetireCount(RetireCount2)
  );

  ctl_t act_s, act2_s;
  assign act_s  = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};
  assign act2_s = {PCWrite2, IorD2, MemRead2, MemWrite2, IRWrite2, RegDst2, MemtoReg2, RegWrite2,
                   ALUSrcA2, ALUSrcB2, ALUOp2, PCSource2, Illegal2};

  int   n_chk = 0;
  int   n_fail = 0;
  row_t tbl[$];
  row_t sb[$];
  int   a_end, b_end;

  ctl_t C_RST, C_FRDY, C_FWAIT, C_DEC, C_MADR, C_MRD, C_MWB, C_MWR, C_EXA, C_EXO, C_RWB;
  ctl_t C_BR1, C_BR0, C_JMP, C_AEX, C_AWB, C_TRAP;

  function automatic ctl_t mk(input logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca,
                              input logic [1:0] srcb, input logic [5:0] aluop,
                              input logic [1:0] pcsrc, input logic ill);
    mk = {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aluop, pcsrc, ill};
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s id=%0d got=%h expected=%h", nm, id, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, fn, input logic z, rdy, input logic [3:0] st,
                     input ctl_t ctl, input logic [31:0] cnt);
    row_t r;
    r.id = tbl.size(); r.op = op; r.fn = fn; r.z = z; r.rdy = rdy;
    r.st = st; r.ctl = ctl; r.cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic run_row(input row_t r);
    @(negedge Clk);
    Opcode = r.op; Funct = r.fn; Zero = r.z; MemReady = r.rdy;
    sb.push_back(r);
  endtask

  task automatic cyc2(input string nm, input int id, input logic [3:0] st, input logic [31:0] cnt);
    chk({nm, "_state"}, id, 32'(State2), 32'(st));
    chk({nm, "_count"}, id, 32'(RetireCount2), cnt);
    @(negedge Clk);
    #2;
  endtask

  // Scoreboard: compare each driven row against the DUT just before the next rising edge.
  initial begin
    row_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", e.id, 32'(State), 32'(e.st));
        chk("ctl", e.id, 32'(act_s), 32'(e.ctl));
        chk("count", e.id, RetireCount, e.cnt);
      end
    end
  end

  initial begin
    Rst = 1'b0; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b0;
    Rst2 = 1'b0; Opcode2 = 6'd0; Funct2 = 6'd0; Zero2 = 1'b0; MemReady2 = 1'b0;

    //         pcw   iord  mrd   mwr   irw   rdst  m2r   rw    srca  srcb  aluop  pcsrc ill
    C_RST   = '0;
    C_FRDY  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, F_ADD, 2'd0, 1'b0);
    C_FWAIT = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, F_ADD, 2'd0, 1'b0);
    C_DEC   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, F_ADD, 2'd0, 1'b0);
    C_MADR  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, F_ADD, 2'd0, 1'b0);
    C_MRD   = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, F_ADD, 2'd0, 1'b0);
    C_MWB   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, F_ADD, 2'd0, 1'b0);
    C_MWR   = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, F_ADD, 2'd0, 1'b0);
    C_EXA   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, F_ADD, 2'd0, 1'b0);
    C_EXO   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, F_OR,  2'd0, 1'b0);
    C_RWB   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, F_ADD, 2'd0, 1'b0);
    C_BR1   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, F_SUB, 2'd1, 1'b0);
    C_BR0   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, F_SUB, 2'd1, 1'b0);
    C_JMP   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, F_ADD, 2'd2, 1'b0);
    C_AEX   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, F_ADD, 2'd0, 1'b0);
    C_AWB   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, F_ADD, 2'd0, 1'b0);
    C_TRAP  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, F_ADD, 2'd0, 1'b1);

    // Segment A: add, or, lw with waits, sw with a wait, beq taken/not, addi, j, illegal -> trap
    add(OP_R, F_ADD, 1'b0, 1'b1, 4'd0, C_FRDY, 32'd0);
    add(OP_R, F_ADD, 1'b0, 1'b1, 4'd1, C_DEC,  32'd0);
    add(OP_R, F_ADD, 1'b0, 1'b1, 4'd6, C_EXA,  32'd0);
    add(OP_R, F_ADD, 1'b0, 1'b1, 4'd7, C_RWB,  32'd0);
    add(OP_R, F_OR,  1'b0, 1'b1, 4'd0, C_FRDY, 32'd1);
    add(OP_R, F_OR,  1'b0, 1'b1, 4'd1, C_DEC,  32'd1);
    add(OP_R, F_OR,  1'b0, 1'b1, 4'd6, C_EXO,  32'd1);
    add(OP_R, F_OR,  1'b0, 1'b1, 4'd7, C_RWB,  32'd1);
    add(OP_LW, F_ADD, 1'b0, 1'b0, 4'd0, C_FWAIT, 32'd2);
    add(OP_LW, F_ADD, 1'b0, 1'b0, 4'd0, C_FWAIT, 32'd2);
    add(OP_LW, F_ADD, 1'b0, 1'b1, 4'd0, C_FRDY,  32'd2);
    add(OP_LW, F_ADD, 1'b0, 1'b1, 4'd1, C_DEC,   32'd2);
    add(OP_LW, F_ADD, 1'b0, 1'b1, 4'd2, C_MADR,  32'd2);
    for (int i = 0; i < 3; i++) add(OP_LW, F_ADD, 1'b0, 1'b0, 4'd3, C_MRD, 32'd2);
    add(OP_LW, F_ADD, 1'b0, 1'b1, 4'd3, C_MRD,  32'd2);
    add(OP_LW, F_ADD, 1'b0, 1'b1, 4'd4, C_MWB,  32'd2);
    add(OP_SW, F_ADD, 1'b0, 1'b1, 4'd0, C_FRDY, 32'd3);
    add(OP_SW, F_ADD, 1'b0, 1'b1, 4'd1, C_DEC,  32'd3);
    add(OP_SW, F_ADD, 1'b0, 1'b1, 4'd2, C_MADR, 32'd3);
    add(OP_SW, F_ADD, 1'b0, 1'b0, 4'd5, C_MWR,  32'd3);
    add(OP_SW, F_ADD, 1'b0, 1'b1, 4'd5, C_MWR,  32'd3);
    add(OP_BEQ, F_ADD, 1'b1, 1'b1, 4'd0, C_FRDY, 32'd4);
    add(OP_BEQ, F_ADD, 1'b1, 1'b1, 4'd1, C_DEC,  32'd4);
    add(OP_BEQ, F_ADD, 1'b1, 1'b1, 4'd8, C_BR1,  32'd4);
    add(OP_BEQ, F_ADD, 1'b0, 1'b1, 4'd0, C_FRDY, 32'd5);
    add(OP_BEQ, F_ADD, 1'b0, 1'b1, 4'd1, C_DEC,  32'd5);
    add(OP_BEQ, F_ADD, 1'b0, 1'b1, 4'd8, C_BR0,  32'd5);
    add(OP_ADDI, F_ADD, 1'b0, 1'b1, 4'd0,  C_FRDY, 32'd6);
    add(OP_ADDI, F_ADD, 1'b0, 1'b1, 4'd1,  C_DEC,  32'd6);
    add(OP_ADDI, F_ADD, 1'b0, 1'b1, 4'd10, C_AEX,  32'd6);
    add(OP_ADDI, F_ADD, 1'b0, 1'b1, 4'd11, C_AWB,  32'd6);
    add(OP_J, F_ADD, 1'b0, 1'b1, 4'd0, C_FRDY, 32'd7);
    add(OP_J, F_ADD, 1'b0, 1'b1, 4'd1, C_DEC,  32'd7);
    add(OP_J, F_ADD, 1'b0, 1'b1, 4'd9, C_JMP,  32'd7);
    add(OP_ILL, F_ADD, 1'b0, 1'b1, 4'd0, C_FRDY, 32'd8);
    add(OP_ILL, F_ADD, 1'b0, 1'b1, 4'd1, C_DEC,  32'd8);
    for (int i = 0; i < 21; i++) add(OP_ILL, F_ADD, logic'(i[1]), logic'(i[0]), 4'd12, C_TRAP, 32'd8);
    a_end = tbl.size();
    // Segment B: sw stalled in MEMWR, aborted by reset
    add(OP_SW, F_ADD, 1'b0, 1'b1, 4'd0, C_FRDY, 32'd0);
    add(OP_SW, F_ADD, 1'b0, 1'b1, 4'd1, C_DEC,  32'd0);
    add(OP_SW, F_ADD, 1'b0, 1'b1, 4'd2, C_MADR, 32'd0);
    add(OP_SW, F_ADD, 1'b0, 1'b0, 4'd5, C_MWR,  32'd0);
    add(OP_SW, F_ADD, 1'b0, 1'b0, 4'd5, C_MWR,  32'd0);
    b_end = tbl.size();
    // Segment C: normal operation after the abort
    add(OP_R, F_ADD, 1'b0, 1'b1, 4'd0, C_FRDY,  32'd0);
    add(OP_R, F_ADD, 1'b0, 1'b1, 4'd1, C_DEC,   32'd0);
    add(OP_R, F_ADD, 1'b0, 1'b1, 4'd6, C_EXA,   32'd0);
    add(OP_R, F_ADD, 1'b0, 1'b1, 4'd7, C_RWB,   32'd0);
    add(OP_R, F_ADD, 1'b0, 1'b0, 4'd0, C_FWAIT, 32'd1);

    #7;
    chk("rst_state", -1, 32'(State), 32'd0);
    chk("rst_ctl",   -1, 32'(act_s), 32'(C_RST));
    chk("rst_count", -1, RetireCount, 32'd0);
    chk("rst2_ctl",  -1, 32'(act2_s), 32'(C_RST));
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = 0; i < a_end; i++) run_row(tbl[i]);
    #3;
    Rst = 1'b0; MemReady = 1'b0;
    #1;
    chk("trap_exit_state", -2, 32'(State), 32'd0);
    chk("trap_exit_ctl",   -2, 32'(act_s), 32'(C_RST));
    chk("trap_exit_count", -2, RetireCount, 32'd0);
    @(negedge Clk);
    Rst = 1'b1;

    for (int i = a_end; i < b_end; i++) run_row(tbl[i]);
    #3;
    Rst = 1'b0; MemReady = 1'b0;
    #1;
    chk("abort_memwrite", -3, 32'(MemWrite), 32'd0);
    chk("abort_state",    -3, 32'(State), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_count", -3, RetireCount, 32'd0);
    Rst = 1'b1;

    for (int i = b_end; i < tbl.size(); i++) run_row(tbl[i]);
    #3;
    chk("sb_drain", -4, 32'(sb.size()), 32'd0);

    // Second instance: no memory waits, illegal retires as NOP, 4-bit counter
    @(negedge Clk);
    Rst2 = 1'b1; Opcode2 = OP_J;
    #2;
    chk("nw_fetch_ctl", 100, 32'(act2_s), 32'(C_FRDY));
    for (int k = 0; k < 17; k++) begin
      cyc2("j_fetch",  200 + k, 4'd0, 32'(k % 16));
      cyc2("j_decode", 200 + k, 4'd1, 32'(k % 16));
      cyc2("j_jump",   200 + k, 4'd9, 32'(k % 16));
    end
    chk("wrap_count", 101, 32'(RetireCount2), 32'd1);
    Opcode2 = OP_LW;
    cyc2("nw_lw", 300, 4'd0, 32'd1);
    cyc2("nw_lw", 301, 4'd1, 32'd1);
    cyc2("nw_lw", 302, 4'd2, 32'd1);
    cyc2("nw_lw", 303, 4'd3, 32'd1);
    cyc2("nw_lw", 304, 4'd4, 32'd1);
    Opcode2 = OP_ILL;
    cyc2("nop_ill", 400, 4'd0, 32'd2);
    cyc2("nop_ill", 401, 4'd1, 32'd2);
    chk("nop_state",   402, 32'(State2), 32'd0);
    chk("nop_count",   402, 32'(RetireCount2), 32'd3);
    chk("nop_illegal", 402, 32'(Illegal2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
